// File: rtl/data_display_pkg.sv
// Shared definitions for the data_display block: FSM state encoding,
// segment constants, decimal range limit and the 0-F glyph table.
// Segments are active-low, bit6 = g ... bit0 = a.
package data_display_pkg;

  localparam int DIGITS = 8;
  localparam logic [31:0] DEC_MAX_DEFAULT = 32'd99999999;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;  // lowercase b
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;  // lowercase d
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Nibble to active-low glyph lookup.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/data_display_if.sv
// Bus between the calculator (master) and the display block (slave):
// the DATA result, the format select, the busy flag and the eight digits.
interface data_display_if;
  logic [31:0] DATA;
  logic        DEC_MODE;
  logic        BUSY;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  modport master (
    output DATA, DEC_MODE,
    input  BUSY, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  DATA, DEC_MODE,
    output BUSY, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );
endinterface

// File: rtl/data_display_seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decoder with a blank override.
module seg7_decode
  import data_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : glyph(nibble_i);

endmodule

// File: rtl/data_display.sv
// Renders the 32-bit DATA bus on eight seven-segment digits, in hex or in
// unsigned decimal (sequential double-dabble, 32 shifts). Digits are only
// updated once a conversion completes; any input change restarts it.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero digit (overflow dashes are never blanked).
module data_display
  import data_display_pkg::*;
#(
  parameter logic [31:0] DEC_MAX = DEC_MAX_DEFAULT
) (
  input  logic            CLOCK_50,
  input  logic            KEY0,
  data_display_if.slave   bus
);

  state_t      state_q;
  logic [31:0] data_q;
  logic        mode_q;
  logic        pending_q;
  logic        busy_q;
  logic [63:0] sr_q;
  logic [4:0]  cnt_q;
  logic [6:0]  hex_q [DIGITS];

  logic [63:0] sr_adj;
  logic [63:0] sr_d;
  logic [3:0]  digit  [DIGITS];
  logic [6:0]  seg_dec [DIGITS];
  logic [6:0]  seg_d  [DIGITS];
  logic [DIGITS-1:0] blank;
  logic        trigger;
  logic        overflow;

  // Any pending request or input difference starts (or restarts) a conversion.
  assign trigger  = pending_q | (bus.DATA != data_q) | (bus.DEC_MODE != mode_q);
  assign overflow = mode_q && (data_q > DEC_MAX);

  // Low half of the shift register carries the binary operand untouched.
  assign sr_adj[31:0] = sr_q[31:0];
  assign sr_d         = sr_adj << 1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Add-3 correction on every BCD nibble before the shift.
      assign sr_adj[32 + 4*gi +: 4] = (sr_q[32 + 4*gi +: 4] >= 4'd5) ?
                                      sr_q[32 + 4*gi +: 4] + 4'd3 :
                                      sr_q[32 + 4*gi +: 4];

      // After 32 shifts the upper half holds the BCD result.
      assign digit[gi] = mode_q ? sr_q[32 + 4*gi +: 4] : data_q[4*gi +: 4];

      seg7_decode u_seg (
        .nibble_i (digit[gi]),
        .blank_i  (blank[gi]),
        .seg_o    (seg_dec[gi])
      );

      assign seg_d[gi] = overflow ? SEG_DASH : seg_dec[gi];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[i]: digit i and everything above it is zero. HEX0 always shows.
  logic [DIGITS-1:1] upper_zero;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lzb
      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = (digit[gi] == 4'd0);
      end else begin : g_mid
        assign upper_zero[gi] = (digit[gi] == 4'd0) && upper_zero[gi+1];
      end
      assign blank[gi] = upper_zero[gi];
    end
  endgenerate
  assign blank[0] = 1'b0;
`else
  assign blank = '0;
`endif

  // Conversion FSM: capture/restart on trigger, shift 32 times, latch at DONE.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      mode_q    <= 1'b0;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else if (trigger) begin
      data_q    <= bus.DATA;
      mode_q    <= bus.DEC_MODE;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
      cnt_q     <= '0;
      if (bus.DEC_MODE) begin
        sr_q    <= {32'd0, bus.DATA};
        state_q <= ST_SHIFT;
      end else begin
        state_q <= ST_DONE;
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= ST_DONE;
        end
        ST_DONE: begin
          for (int i = 0; i < DIGITS; i++) hex_q[i] <= seg_d[i];
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.HEX0 = hex_q[0];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX5 = hex_q[5];
  assign bus.HEX6 = hex_q[6];
  assign bus.HEX7 = hex_q[7];

endmodule

// File: tb/tb_data_display.sv
// Directed table-driven bench for data_display plus hand-written sequences
// for abort-on-change and reset during a conversion.
module tb_data_display;

  logic clk = 1'b0;
  logic rst_n;

  data_display_if bus ();

  data_display dut (
    .CLOCK_50 (clk),
    .KEY0     (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        mode;
    int          busy;
    string       exp;   // HEX7..HEX0 as characters
  } vec_t;

  vec_t vecs [11];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

  function automatic logic [6:0] glyph_of(input byte c);
    logic [6:0] g;
    case (c)
      "0": g = 7'h40;  "1": g = 7'h79;  "2": g = 7'h24;  "3": g = 7'h30;
      "4": g = 7'h19;  "5": g = 7'h12;  "6": g = 7'h02;  "7": g = 7'h78;
      "8": g = 7'h00;  "9": g = 7'h10;  "A": g = 7'h08;  "b": g = 7'h03;
      "C": g = 7'h46;  "d": g = 7'h21;  "E": g = 7'h06;  "F": g = 7'h0E;
      "-": g = 7'h3F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  function automatic logic [55:0] expect_of(input string s);
    logic [55:0] r;
    string t;
    bit    lead;
    t    = s;
    lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 7; i++) begin
      if (lead && t[i] == "0") t.putc(i, 8'h20);
      else lead = 1'b0;
    end
`endif
    for (int i = 0; i < 8; i++) r[55 - 7*i -: 7] = glyph_of(t[i]);
    return r;
  endfunction

  function automatic logic [55:0] hex_now();
    return {bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4,
            bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  task automatic check56(input string name, input logic [55:0] act, input logic [55:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Clock until BUSY drops (bounded); check busy length, held digits, result.
  task automatic run_conv(input string name, input logic [55:0] prev,
                          input int exp_busy, input string exp_s);
    int edges;
    bit held;
    bit done;
    edges = 0;
    held  = 1'b1;
    done  = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (!bus.BUSY) done = 1'b1;
      else if (hex_now() !== prev) held = 1'b0;
    end
    check_int({name, " busy cycles"}, edges - 1, exp_busy);
    check_int({name, " held"}, int'(held), 1);
    check56({name, " hex"}, hex_now(), expect_of(exp_s));
    $display("vec %-12s busy=%0d hex=%h", name, edges - 1, hex_now());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] prev;

    vecs[0]  = '{"hex_1234", 32'h1234ABCD, 1'b0,  1, "1234AbCd"};
    vecs[1]  = '{"dec_1234", 32'd12345678, 1'b1, 33, "12345678"};
    vecs[2]  = '{"dec_ovf",  32'd100000000, 1'b1, 33, "--------"};
    vecs[3]  = '{"dec_max",  32'd99999999, 1'b1, 33, "99999999"};
    vecs[4]  = '{"hex_ffff", 32'hFFFFFFFF, 1'b0,  1, "FFFFFFFF"};
    vecs[5]  = '{"dec_zero", 32'd0,        1'b1, 33, "00000000"};
    vecs[6]  = '{"hex_f00",  32'h00000F00, 1'b0,  1, "00000F00"};
    vecs[7]  = '{"dec_42",   32'd42,       1'b1, 33, "00000042"};
    vecs[8]  = '{"hex_mix",  32'h89E56D70, 1'b0,  1, "89E56d70"};
    vecs[9]  = '{"dec_umax", 32'hFFFFFFFF, 1'b1, 33, "--------"};
    vecs[10] = '{"dec_10",   32'd10,       1'b1, 33, "00000010"};

    // Reset state, then the forced post-reset conversion.
    rst_n        = 1'b0;
    bus.DATA     = 32'd0;
    bus.DEC_MODE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check56("reset hex", hex_now(), ALL_BLANK);
    check_int("reset busy", int'(bus.BUSY), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("post_reset", ALL_BLANK, 1, "00000000");

    // Table of single conversions from idle.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.DATA     = vecs[i].data;
      bus.DEC_MODE = vecs[i].mode;
      prev = hex_now();
      run_conv(vecs[i].name, prev, vecs[i].busy, vecs[i].exp);
    end

    // Abort: 500 in decimal, replaced by 42 at shift cycle 10.
    @(negedge clk);
    bus.DATA     = 32'd500;
    bus.DEC_MODE = 1'b1;
    prev = hex_now();
    repeat (11) @(posedge clk);
    @(negedge clk);
    check_int("abort busy before change", int'(bus.BUSY), 1);
    check56("abort hex before change", hex_now(), prev);
    bus.DATA = 32'd42;
    run_conv("abort_42", prev, 33, "00000042");

    // Reset at shift cycle 20, then reconversion of the current DATA.
    @(negedge clk);
    bus.DATA = 32'd87654321;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check56("midreset hex", hex_now(), ALL_BLANK);
    check_int("midreset busy", int'(bus.BUSY), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_conv("after_reset", ALL_BLANK, 33, "87654321");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
